// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding, fixed stage indices and
// default sizing for the in-order core pipeline.
package pipe_ctrl_pkg;

  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_EX_STAGE   = 2;
  localparam int DEF_MEM_STAGE  = 3;
  localparam int DEF_RADDR_W    = 5;
  localparam int DEF_CNT_W      = 16;

  localparam int STG_FETCH = 0;
  localparam int STG_DEC   = 1;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH      = 2'd1,
    ST_LOAD_STALL = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: decode sources against the EX-stage load destination.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               dec_valid,
  input  logic               ex_valid,
  input  logic               ex_load,
  input  logic [RADDR_W-1:0] ex_rd_addr,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [1:0]         rs_used,
  output logic               load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = rs_used[0] && (rs1_addr == ex_rd_addr);
  assign rs2_hit  = rs_used[1] && (rs2_addr == ex_rd_addr);
  // x0 is hardwired, so a load targeting it never creates a dependency
  assign load_use = dec_valid && ex_valid && ex_load && (ex_rd_addr != '0) &&
                    (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage valid tracking, stall/flush generation for
// memory wait, taken branch and load-use, plus saturating event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int EX_STAGE   = DEF_EX_STAGE,
  parameter int MEM_STAGE  = DEF_MEM_STAGE,
  parameter int RADDR_W    = DEF_RADDR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  fetch_valid_i,
  input  logic                  branch_en_i,
  input  logic [RADDR_W-1:0]    dec_rs1_addr_i,
  input  logic [RADDR_W-1:0]    dec_rs2_addr_i,
  input  logic [1:0]            dec_rs_used_i,
  input  logic [RADDR_W-1:0]    ex_rd_addr_i,
  input  logic                  ex_load_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  pipe_state_e           state_q, state_d;
  logic [NUM_STAGES-1:0] vld_q, vld_d, adv;
  logic [NUM_STAGES-1:0] stall_raw, flush;
  logic [CNT_W-1:0]      stall_cnt_q, flush_cnt_q;
  logic                  mem_wait, branch_acc, load_use, load_take;

  hazard_detect #(.RADDR_W(RADDR_W)) u_hazard (
    .dec_valid  (vld_q[STG_DEC]),
    .ex_valid   (vld_q[EX_STAGE]),
    .ex_load    (ex_load_i),
    .ex_rd_addr (ex_rd_addr_i),
    .rs1_addr   (dec_rs1_addr_i),
    .rs2_addr   (dec_rs2_addr_i),
    .rs_used    (dec_rs_used_i),
    .load_use   (load_use)
  );

  // Priority: mem wait masks a branch (EX keeps presenting it), branch masks load-use
  assign mem_wait   = vld_q[MEM_STAGE] && mem_req_i && !mem_ready_i;
  assign branch_acc = vld_q[EX_STAGE] && branch_en_i && !mem_wait;
  assign load_take  = load_use && !mem_wait && !branch_acc;

  always_comb begin
    state_d   = ST_RUN;
    stall_raw = '0;
    flush     = '0;
    if (reset_i) begin
      flush = '1;
    end else begin
      // one redirect bubble into fetch the cycle after a taken branch
      if (state_q == ST_FLUSH) flush[STG_FETCH] = 1'b1;
      if (mem_wait) begin
        state_d = ST_MEM_WAIT;
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (k <= MEM_STAGE)    stall_raw[k] = 1'b1;
          if (k == MEM_STAGE + 1) flush[k]    = 1'b1;
        end
      end else if (branch_acc) begin
        state_d = ST_FLUSH;
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (k <= EX_STAGE) flush[k] = 1'b1;
        end
      end else if (load_take) begin
        state_d              = ST_LOAD_STALL;
        stall_raw[STG_FETCH] = 1'b1;
        stall_raw[STG_DEC]   = 1'b1;
        flush[EX_STAGE]      = 1'b1;
      end
    end
  end

  assign stall_o = stall_raw & ~flush;
  assign flush_o = flush;

  assign adv   = {vld_q[NUM_STAGES-2:0], fetch_valid_i};
  assign vld_d = (adv & ~stall_o & ~flush) | (vld_q & stall_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      vld_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      if ((|stall_o) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (branch_acc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stage_valid_o = vld_q;
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: NUM_STAGES, 5, pipeline depth (legal 4..8); EX_STAGE, 2, branch-resolve/load-detect stage index; MEM_STAGE, 3, data-memory stage index (= EX_STAGE+1); RADDR_W, 5, register address width; CNT_W, 16, performance counter width.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high. Ports: clk_i  in  1  system clock; reset_i  in  1  synchronous active-high reset.
REQ-003 fetch_valid_i  in  1  stage-0 instruction returned valid this cycle.
REQ-004 branch_en_i  in  1  taken branch/jump resolved in EX_STAGE.
REQ-005 dec_rs1_addr_i, dec_rs2_addr_i  in  RADDR_W  decode-stage source registers; dec_rs_used_i  in  2  bit0 = rs1 used, bit1 = rs2 used.
REQ-006 ex_rd_addr_i  in  RADDR_W  EX_STAGE destination; ex_load_i  in  1  EX_STAGE instruction is a load.
REQ-007 mem_req_i  in  1  MEM_STAGE issues a data access; mem_ready_i  in  1  data memory accepts/completes the access this cycle.
REQ-008 stage_valid_o  out  NUM_STAGES  per-stage valid bits; stall_o  out  NUM_STAGES  hold stage register; flush_o  out  NUM_STAGES  load bubble into stage register.
REQ-009 state_o  out  2  FSM state; stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters.

Function
REQ-010 FSM states SHALL be RUN(0), FLUSH(1), LOAD_STALL(2), MEM_WAIT(3).
REQ-011 Event priority SHALL be mem-wait > branch > load-use, evaluated each cycle.
REQ-012 mem_wait SHALL assert when stage_valid_o[MEM_STAGE] & mem_req_i & !mem_ready_i.
REQ-013 During mem_wait: stall_o[0..MEM_STAGE]=1, flush_o[MEM_STAGE+1]=1, stages 0..MEM_STAGE keep valid bits, state=MEM_WAIT; exit to RUN in the cycle mem_ready_i rises (zero added latency).
REQ-014 branch_en_i SHALL be ignored unless stage_valid_o[EX_STAGE]=1; branch arriving during MEM_WAIT SHALL be deferred; EX holds branch_en_i while stalled, so it is acted on in the release cycle.
REQ-015 Accepted branch: flush_o[0..EX_STAGE]=1 same cycle, next-cycle valid of stages 1..EX_STAGE = 0, state FLUSH for exactly one cycle.
REQ-016 In FLUSH: stage 0 loads a bubble regardless of fetch_valid_i (redirect latency); return to RUN next cycle.
REQ-017 load_use SHALL assert when stage_valid_o[1] & stage_valid_o[EX_STAGE] & ex_load_i & ex_rd_addr_i!=0 & ((dec_rs_used_i[0] & rs1==rd) | (dec_rs_used_i[1] & rs2==rd)).
REQ-018 On load_use: stall_o[0..1]=1, flush_o[EX_STAGE]=1, state LOAD_STALL for one cycle, then RUN; a second hazard in LOAD_STALL SHALL re-stall.
REQ-019 RUN advance: valid[0]<=fetch_valid_i; valid[k]<=valid[k-1] for unstalled, unflushed k.
REQ-020 Stall and flush SHALL never assert on the same stage in one cycle; flush wins if the FSM would produce both.
REQ-021 stall_cnt_o SHALL increment on every cycle with any stall_o bit set; flush_cnt_o on every accepted branch; both saturate at 2^CNT_W-1 without wrap.
REQ-022 stall_o/flush_o SHALL be combinational from current state and inputs; valid bits, state and counters registered.

Reset
REQ-023 reset_i SHALL clear, on the next clock edge: stage_valid_o=0, state=RUN, counters=0; stall_o=0 and flush_o=all-ones while reset_i is high.
REQ-024 Reset mid-MEM_WAIT or mid-FLUSH SHALL abandon the event; no deferred branch survives reset.

Structure
REQ-025 State enum, stage-index constants and default parameters SHALL reside in the shared core package.
REQ-026 Hazard comparator SHALL be one sub-module, hazard_detect (combinational load_use output); remainder in pipe_ctrl.

Verification
REQ-027 Fill: reset, fetch_valid_i=1 for 6 cycles -> stage_valid_o = 00001, 00011 ... 11111, state RUN.
REQ-028 Branch: full pipe, branch_en_i=1 one cycle -> flush_o=00111 that cycle, next stage_valid_o=11000, state FLUSH one cycle, flush_cnt_o=1.
REQ-029 Load-use: ex_load_i=1, ex_rd=5, dec_rs1=5, used=01 -> stall_o=00011, flush_o=00100, one LOAD_STALL cycle; rd=0 -> no stall.
REQ-030 Mem wait: mem_req_i=1, mem_ready_i=0 for 3 cycles -> stall_o=01111, flush_o=10000, stall_cnt_o=3, RUN when ready.
REQ-031 Simultaneous: mem wait + branch -> branch deferred, flush_o=00111 in release cycle; reset_i pulse mid-wait -> valids 0, state RUN, counters 0.
REQ-032 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt_o holds 15.
